// File: rtl/dcache_store_responder.sv
// -----------------------------------------------------------------------------
// dcache_store_responder
//
// Responder end of the D$ store request port. Grants and acknowledges store
// requests, buffers them in a small in-order write FIFO and drains them one
// beat at a time to a single-beat memory write interface.
//
// Optional feature (compile-time macro): STORE_RESP_MERGE_EN
//   Defined   : a granted write to the same word as the youngest FIFO entry is
//               byte-merged into that entry instead of allocating a new one.
//   Undefined : every granted write allocates a new entry.
//
// Parameters
//   DEPTH        write FIFO entries (power of two, >= 2)
//   XLEN / PLEN  come from dcache_store_responder_pkg (core configuration)
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   req_port_i   store request (dcache_req_i_t)
//   req_port_o   response: data_gnt (combinational), data_rvalid/data_rid
//                one cycle after each grant, data_rdata/data_ruser tied to 0
//   mem_req_o    memory write request, held with stable payload until mem_gnt_i
//   mem_addr_o   word-aligned byte address of the beat
//   mem_wdata_o  beat write data
//   mem_be_o     beat byte enables
//   mem_gnt_i    memory accepted the current beat
//   empty_o      FIFO empty and no beat outstanding
//   err_o        one-cycle pulse after each cycle a read request was presented
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package dcache_store_responder_pkg;

  localparam int unsigned XLEN               = 64;
  localparam int unsigned PLEN               = 56;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = PLEN - DCACHE_INDEX_WIDTH;
  localparam int unsigned DCACHE_TID_WIDTH   = 4;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [XLEN-1:0]               data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [XLEN/8-1:0]             data_be;
    logic [1:0]                    data_size;
    logic [DCACHE_TID_WIDTH-1:0]   data_id;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic                        data_gnt;
    logic                        data_rvalid;
    logic [DCACHE_TID_WIDTH-1:0] data_rid;
    logic [XLEN-1:0]             data_rdata;
    logic                        data_ruser;
  } dcache_req_o_t;

endpackage

module dcache_store_responder
  import dcache_store_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  dcache_req_i_t       req_port_i,
  output dcache_req_o_t       req_port_o,
  output logic                mem_req_o,
  output logic [PLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  input  logic                mem_gnt_i,
  output logic                empty_o,
  output logic                err_o
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFFS  = $clog2(BE_W);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  // FIFO storage
  logic [PLEN-1:0] fifo_addr  [DEPTH];
  logic [XLEN-1:0] fifo_wdata [DEPTH];
  logic [BE_W-1:0] fifo_be    [DEPTH];
  logic [1:0]      fifo_size  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_n;
  logic [0:0]       state_q, state_n;

  logic [PLEN-1:0] full_addr, word_addr;
  logic            write_ok, not_full, gnt, push, pop;

  logic                        rvalid_q;
  logic [DCACHE_TID_WIDTH-1:0] rid_q;
  logic                        err_q;

  assign full_addr = {req_port_i.address_tag, req_port_i.address_index};
  assign word_addr = {full_addr[PLEN-1:OFFS], {OFFS{1'b0}}};

  assign write_ok = req_port_i.data_req & req_port_i.data_we &
                    req_port_i.tag_valid & ~req_port_i.kill_req;

  // Readiness comes from the registered count only; a pop in the same cycle
  // does not open a slot until the next cycle (no path from mem_gnt_i).
  assign not_full = (count_q != FULL_CNT);
  assign pop      = (state_q == ISSUE) & mem_gnt_i;

`ifdef STORE_RESP_MERGE_EN
  logic [PTR_W-1:0] young_ptr;
  logic             merge_hit, merge;

  assign young_ptr = wr_ptr_q - PTR_W'(1);

  // The youngest entry must not be merged while it is the head beat already
  // presented on the bus, otherwise the payload would change under the memory.
  assign merge_hit = (count_q != '0) &&
                     (fifo_addr[young_ptr] == word_addr) &&
                     !((young_ptr == rd_ptr_q) && (state_q == ISSUE));

  assign gnt   = write_ok & (not_full | merge_hit);
  assign merge = gnt & merge_hit;
  assign push  = gnt & ~merge_hit;
`else
  assign gnt  = write_ok & not_full;
  assign push = gnt;
`endif

  assign count_n = count_q + CNT_W'(push) - CNT_W'(pop);

  // Drain FSM. IDLE looks at the post-push count so a freshly pushed entry is
  // presented on the bus the very next cycle.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    state_n = state_q;
    case (state_q)
      IDLE:    if (count_n != '0) state_n = ISSUE;
      ISSUE:   if (pop && (count_n == '0)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control state: pointers, count, FSM, ack and error pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      rvalid_q <= gnt;
      if (gnt) rid_q <= req_port_i.data_id;
      err_q    <= req_port_i.data_req & ~req_port_i.data_we;
    end
  end

  // NOTE: the entry array is deliberately not reset; an entry is only read
  // after it has been written, and resetting it would turn cheap storage into
  // resettable flops for no functional gain.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr_q]  <= word_addr;
      fifo_wdata[wr_ptr_q] <= req_port_i.data_wdata;
      fifo_be[wr_ptr_q]    <= req_port_i.data_be;
      fifo_size[wr_ptr_q]  <= req_port_i.data_size;
    end
`ifdef STORE_RESP_MERGE_EN
    if (merge) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (req_port_i.data_be[b]) begin
          fifo_wdata[young_ptr][8*b +: 8] <= req_port_i.data_wdata[8*b +: 8];
        end
      end
      fifo_be[young_ptr] <= fifo_be[young_ptr] | req_port_i.data_be;
    end
`endif
  end

  // Beat payload is gated so the bus idles at zero and never shows
  // uninitialised storage.
  assign mem_req_o   = (state_q == ISSUE);
  assign mem_addr_o  = mem_req_o ? fifo_addr[rd_ptr_q]  : '0;
  assign mem_wdata_o = mem_req_o ? fifo_wdata[rd_ptr_q] : '0;
  assign mem_be_o    = mem_req_o ? fifo_be[rd_ptr_q]    : '0;

  assign empty_o = (count_q == '0) & (state_q == IDLE);
  assign err_o   = err_q;

  always_comb begin
    req_port_o             = '0;
    req_port_o.data_gnt    = gnt;
    req_port_o.data_rvalid = rvalid_q;
    req_port_o.data_rid    = rid_q;
  end

  // The stored access size travels with the entry but byte enables define the
  // beat; the sub-word address bits are likewise dropped.
  logic unused_bits;
  assign unused_bits = ^{full_addr[OFFS-1:0], fifo_size[rd_ptr_q]};

endmodule

// File: tb/tb_dcache_store_responder.sv
`timescale 1ns/1ps

module tb_dcache_store_responder;
  import dcache_store_responder_pkg::*;

  localparam int DEPTH = 4;

  logic                clk_i = 1'b0;
  logic                rst_i;
  dcache_req_i_t       req_port_i;
  dcache_req_o_t       req_port_o;
  logic                mem_req_o;
  logic [PLEN-1:0]     mem_addr_o;
  logic [XLEN-1:0]     mem_wdata_o;
  logic [XLEN/8-1:0]   mem_be_o;
  logic                mem_gnt_i;
  logic                empty_o;
  logic                err_o;

  dcache_store_responder #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_port_i (req_port_i),
    .req_port_o (req_port_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_be_o   (mem_be_o),
    .mem_gnt_i  (mem_gnt_i),
    .empty_o    (empty_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [PLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] be;
  } beat_t;

  beat_t beat_q[$];
  beat_t exp_q[$];

  // Record each beat the memory accepts (sampled mid-cycle, before the edge).
  always @(negedge clk_i) begin
    if (!rst_i && mem_req_o && mem_gnt_i) beat_q.push_back({mem_addr_o, mem_wdata_o, mem_be_o});
  end

  typedef struct {
    logic       req, we, tv, kill;
    logic [3:0] id;
    logic       exp_gnt, exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic req, input logic we, input logic tv, input logic kill,
                         input logic [PLEN-1:0] addr, input logic [XLEN-1:0] data,
                         input logic [7:0] be, input logic [3:0] id);
    req_port_i.data_req      = req;
    req_port_i.data_we       = we;
    req_port_i.tag_valid     = tv;
    req_port_i.kill_req      = kill;
    req_port_i.address_index = addr[DCACHE_INDEX_WIDTH-1:0];
    req_port_i.address_tag   = addr[PLEN-1:DCACHE_INDEX_WIDTH];
    req_port_i.data_wdata    = data;
    req_port_i.data_be       = be;
    req_port_i.data_size     = 2'd3;
    req_port_i.data_id       = id;
  endtask

  task automatic idle_req();
    set_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 8'h00, 4'h0);
  endtask

  function automatic beat_t mk(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                               input logic [7:0] b);
    return {a, d, b};
  endfunction

  // Holds a write until granted (bounded), then checks the ack one cycle later.
  task automatic do_write(input logic [PLEN-1:0] addr, input logic [XLEN-1:0] data,
                          input logic [7:0] be, input logic [3:0] id, output int waited);
    bit granted = 1'b0;
    waited = 0;
    set_req(1'b1, 1'b1, 1'b1, 1'b0, addr, data, be, id);
    for (int i = 0; i < 20 && !granted; i++) begin
      #1;
      if (req_port_o.data_gnt) granted = 1'b1;
      else waited++;
      tick();
    end
    idle_req();
    check("wr_granted", granted, 1'b1);
    if (granted) begin
      check("ack_rvalid", req_port_o.data_rvalid, 1'b1);
      check("ack_rid", req_port_o.data_rid, id);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && !empty_o; i++) tick();
    check("drain_empty", empty_o, 1'b1);
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_nbeats"}, beat_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      check({tag, "_addr"}, beat_q[i].addr, exp_q[i].addr);
      check({tag, "_data"}, beat_q[i].data, exp_q[i].data);
      check({tag, "_be"},   beat_q[i].be,   exp_q[i].be);
    end
    beat_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    logic [PLEN-1:0] a;

    //            req we  tv  kill id     gnt err
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h4, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h9, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 1'b1, 1'b0};

    // ---------------- reset values ----------------
    rst_i     = 1'b1;
    mem_gnt_i = 1'b0;
    idle_req();
    tick();
    tick();
    check("rst_gnt",    req_port_o.data_gnt, 1'b0);
    check("rst_rvalid", req_port_o.data_rvalid, 1'b0);
    check("rst_rid",    req_port_o.data_rid, 4'h0);
    check("rst_memreq", mem_req_o, 1'b0);
    check("rst_addr",   mem_addr_o, '0);
    check("rst_wdata",  mem_wdata_o, '0);
    check("rst_be",     mem_be_o, '0);
    check("rst_err",    err_o, 1'b0);
    check("rst_empty",  empty_o, 1'b1);
    rst_i = 1'b0;
    tick();

    // ---------------- single write ----------------
    mem_gnt_i = 1'b1;
    do_write(56'h80000010, 64'h1122334455667788, 8'hFF, 4'h3, w);
    check("single_gnt_same_cycle", w, 0);
    check("single_memreq", mem_req_o, 1'b1);
    check("single_addr",   mem_addr_o, 56'h80000010);
    check("single_wdata",  mem_wdata_o, 64'h1122334455667788);
    check("single_be",     mem_be_o, 8'hFF);
    tick();
    check("single_memreq_done", mem_req_o, 1'b0);
    check("single_empty", empty_o, 1'b1);
    check("single_rvalid_once", req_port_o.data_rvalid, 1'b0);
    exp_q.push_back(mk(56'h80000010, 64'h1122334455667788, 8'hFF));
    compare_beats("single");

    // ---------------- table: grant / kill / read / err ----------------
    for (int i = 0; i < 10; i++) begin
      a = 56'h80000100 + 56'(8 * i);
      set_req(vecs[i].req, vecs[i].we, vecs[i].tv, vecs[i].kill, a,
              {32'hC0DE0000, 32'(i)}, 8'hFF, vecs[i].id);
      #1;
      check($sformatf("vec%0d_gnt", i), req_port_o.data_gnt, vecs[i].exp_gnt);
      tick();
      idle_req();
      check($sformatf("vec%0d_rvalid", i), req_port_o.data_rvalid, vecs[i].exp_gnt);
      check($sformatf("vec%0d_err", i), err_o, vecs[i].exp_err);
      if (vecs[i].exp_gnt) begin
        check($sformatf("vec%0d_rid", i), req_port_o.data_rid, vecs[i].id);
        exp_q.push_back(mk(a, {32'hC0DE0000, 32'(i)}, 8'hFF));
      end
    end
    wait_drain(20);
    compare_beats("table");

    // read held for two cycles: one err pulse per cycle
    set_req(1'b1, 1'b0, 1'b1, 1'b0, 56'h80000200, '0, 8'h00, 4'h1);
    tick();
    check("rd2_err_c1", err_o, 1'b1);
    check("rd2_no_gnt", req_port_o.data_gnt, 1'b0);
    tick();
    idle_req();
    check("rd2_err_c2", err_o, 1'b1);
    tick();
    check("rd2_err_off", err_o, 1'b0);

    // ---------------- backpressure / full ----------------
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_write(56'h80001000 + 56'(i * 16'h100), 64'hA0 + 64'(i), 8'hFF, 4'(i), w);
      check($sformatf("bp_w%0d_immediate", i), w, 0);
    end
    set_req(1'b1, 1'b1, 1'b1, 1'b0, 56'h80001400, 64'hA4, 8'hFF, 4'h4);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp_full_nognt_c%0d", c), req_port_o.data_gnt, 1'b0);
      tick();
    end
    mem_gnt_i = 1'b1;
    do_write(56'h80001400, 64'hA4, 8'hFF, 4'h4, w);
    check("bp_5th_waits_one_pop", w, 1);
    wait_drain(30);
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(56'h80001000 + 56'(i * 16'h100), 64'hA0 + 64'(i), 8'hFF));
    compare_beats("bp");

    // ---------------- simultaneous push/pop at count=2 ----------------
    mem_gnt_i = 1'b0;
    do_write(56'h80003000, 64'hB0, 8'h0F, 4'h0, w);
    do_write(56'h80003008, 64'hB1, 8'hF0, 4'h1, w);
    mem_gnt_i = 1'b1;
    set_req(1'b1, 1'b1, 1'b1, 1'b0, 56'h80003010, 64'hB2, 8'h3C, 4'h2);
    #1;
    check("pp_gnt", req_port_o.data_gnt, 1'b1);
    tick();
    idle_req();
    mem_gnt_i = 1'b0;
    check("pp_ack", req_port_o.data_rvalid, 1'b1);
    check("pp_head_advanced", mem_addr_o, 56'h80003008);
    do_write(56'h80003018, 64'hB3, 8'h01, 4'h3, w);
    check("pp_d_immediate", w, 0);
    do_write(56'h80003020, 64'hB4, 8'h80, 4'h4, w);
    check("pp_e_immediate", w, 0);
    set_req(1'b1, 1'b1, 1'b1, 1'b0, 56'h80003028, 64'hB5, 8'hFF, 4'h5);
    #1;
    check("pp_full_nognt", req_port_o.data_gnt, 1'b0);
    tick();
    idle_req();
    check("pp_full_noack", req_port_o.data_rvalid, 1'b0);
    mem_gnt_i = 1'b1;
    wait_drain(30);
    exp_q.push_back(mk(56'h80003000, 64'hB0, 8'h0F));
    exp_q.push_back(mk(56'h80003008, 64'hB1, 8'hF0));
    exp_q.push_back(mk(56'h80003010, 64'hB2, 8'h3C));
    exp_q.push_back(mk(56'h80003018, 64'hB3, 8'h01));
    exp_q.push_back(mk(56'h80003020, 64'hB4, 8'h80));
    compare_beats("pp");

    // ---------------- async reset mid-operation ----------------
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) do_write(56'h80004000 + 56'(i * 8), 64'hC0 + 64'(i), 8'hFF, 4'(i), w);
    check("ar_memreq_before", mem_req_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check("ar_memreq_drop", mem_req_o, 1'b0);
    check("ar_empty", empty_o, 1'b1);
    check("ar_ack_lost", req_port_o.data_rvalid, 1'b0);
    tick();
    rst_i = 1'b0;
    mem_gnt_i = 1'b1;
    repeat (8) tick();
    check("ar_still_empty", empty_o, 1'b1);
    compare_beats("ar");

    // ---------------- same-word writes (merge when enabled) ----------------
    mem_gnt_i = 1'b0;
    do_write(56'h80005000, 64'h0102030405060708, 8'hFF, 4'h6, w);
    do_write(56'h80006000, 64'h00000000000000AA, 8'h01, 4'h7, w);
    do_write(56'h80006000, 64'h000000000000BB00, 8'h02, 4'h8, w);
    mem_gnt_i = 1'b1;
    wait_drain(30);
    exp_q.push_back(mk(56'h80005000, 64'h0102030405060708, 8'hFF));
`ifdef STORE_RESP_MERGE_EN
    exp_q.push_back(mk(56'h80006000, 64'h000000000000BBAA, 8'h03));
`else
    exp_q.push_back(mk(56'h80006000, 64'h00000000000000AA, 8'h01));
    exp_q.push_back(mk(56'h80006000, 64'h000000000000BB00, 8'h02));
`endif
    compare_beats("merge");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
